// File: rtl/fixedpoint.sv
// Q8.8 fixed-point number format and saturating add shared by the weight-update datapath.
package fixedpoint;

    typedef struct packed {
        logic signed [7:0] integer_fixed;
        logic        [7:0] decimal_fixed;
    } fixed_point_t;

    localparam fixed_point_t FP_MAX  = 16'h7FFF;
    localparam fixed_point_t FP_MIN  = 16'h8000;
    localparam fixed_point_t FP_ZERO = 16'h0000;

    // The whole struct is one two's-complement word; a 17-bit sum exposes overflow.
    function automatic fixed_point_t fp_sat_add(input fixed_point_t a, input fixed_point_t b,
                                                 output logic overflow);
        logic signed [15:0] a_s;
        logic signed [15:0] b_s;
        logic signed [16:0] sum;
        fixed_point_t       res;
        a_s      = a;
        b_s      = b;
        sum      = 17'(a_s) + 17'(b_s);
        overflow = sum[16] ^ sum[15];
        if (!overflow) begin
            res = sum[15:0];
        end else if (sum[16]) begin
            res = FP_MIN;
        end else begin
            res = FP_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_sat_adder.sv
// Combinational Q8.8 saturating adder; overflow flags any clamp.
module fp_sat_adder
    import fixedpoint::*;
(
    input  fixed_point_t a_i,
    input  fixed_point_t b_i,
    output fixed_point_t sum_o,
    output logic         ovf_o
);

    always_comb begin
        ovf_o = 1'b0;
        sum_o = fp_sat_add(a_i, b_i, ovf_o);
    end

endmodule

// File: rtl/weight_bank_update.sv
// Weight bank with per-weight delta accumulators; a commit sweeps the
// accumulators into the weights one index per cycle with saturation.
module weight_bank_update
    import fixedpoint::*;
#(
    parameter int NUM_WEIGHTS = 16,
    parameter int IDX_W       = $clog2(NUM_WEIGHTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [IDX_W-1:0] load_idx,
    input  fixed_point_t     load_weight,
    input  logic             delta_valid,
    output logic             delta_ready,
    input  logic [IDX_W-1:0] delta_idx,
    input  fixed_point_t     weight_delta,
    input  logic             commit,
    output logic             busy,
    output logic             done,
    input  logic [IDX_W-1:0] rd_idx,
    output fixed_point_t     rd_weight,
    input  logic             sat_clr,
    output logic             sat_flag
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEIGHTS - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    fixed_point_t     weight_q [NUM_WEIGHTS];
    fixed_point_t     weight_d [NUM_WEIGHTS];
    fixed_point_t     acc_q    [NUM_WEIGHTS];
    fixed_point_t     acc_d    [NUM_WEIGHTS];

    fixed_point_t     acc_sel, acc_sum, apply_sum;
    logic             acc_hit, acc_ovf, apply_ovf, sat_set;

    // Out-of-range indices match no entry, so they read 0 and write nothing.
    always_comb begin
        acc_sel = FP_ZERO;
        acc_hit = 1'b0;
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (delta_idx == IDX_W'(i)) begin
                acc_sel = acc_q[i];
                acc_hit = 1'b1;
            end
        end
    end

    fp_sat_adder u_acc_add (
        .a_i   (acc_sel),
        .b_i   (weight_delta),
        .sum_o (acc_sum),
        .ovf_o (acc_ovf)
    );

    fp_sat_adder u_apply_add (
        .a_i   (weight_q[cnt_q]),
        .b_i   (acc_q[cnt_q]),
        .sum_o (apply_sum),
        .ovf_o (apply_ovf)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        weight_d = weight_q;
        acc_d    = acc_q;
        sat_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                for (int i = 0; i < NUM_WEIGHTS; i++) begin
                    if (load_valid && load_idx == IDX_W'(i)) weight_d[i] = load_weight;
                    if (delta_valid && delta_idx == IDX_W'(i)) acc_d[i] = acc_sum;
                end
                sat_set = delta_valid && acc_hit && acc_ovf;
                if (commit) begin
                    state_d = ST_APPLY;
                    cnt_d   = '0;
                end
            end
            ST_APPLY: begin
                weight_d[cnt_q] = apply_sum;
                acc_d[cnt_q]    = FP_ZERO;
                sat_set         = apply_ovf;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        sat_d = sat_set | (sat_q & ~sat_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            for (int i = 0; i < NUM_WEIGHTS; i++) begin
                weight_q[i] <= FP_ZERO;
                acc_q[i]    <= FP_ZERO;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            weight_q <= weight_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        rd_weight = FP_ZERO;
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_weight = weight_q[i];
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign delta_ready = !busy;
    assign sat_flag    = sat_q;

endmodule

// File: doc/weight_bank_update.md
# weight_bank_update

Per-layer weight storage and update stage placed directly downstream of `gradientdescent`. It accumulates the `weight_delta` values that `gradientdescent` produces, one per weight, during a training batch. On a `commit` pulse it sweeps the bank and adds each accumulated delta into its weight with saturation. The forward-pass neuron logic reads committed weights through a combinational read port.

## Interface
Parameters:
- `NUM_WEIGHTS`, default 16: number of weights (and accumulators) in the bank.
- `IDX_W`, default `$clog2(NUM_WEIGHTS)`: index width.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `load_valid`, input, 1: initialisation write of `load_weight` into `weight[load_idx]`. Honoured only in IDLE.
- `load_idx`, input, `IDX_W`: target index for the initialisation write.
- `load_weight`, input, `fixed_point_t`: initial weight value.
- `delta_valid`, input, 1: a delta is presented.
- `delta_ready`, output, 1: the bank can accept a delta. Equals `!busy`.
- `delta_idx`, input, `IDX_W`: weight the delta belongs to.
- `weight_delta`, input, `fixed_point_t`: the `gradientdescent` output.
- `commit`, input, 1: single-cycle request to apply the accumulators.
- `busy`, output, 1: high in APPLY and DONE.
- `done`, output, 1: one-cycle pulse when a commit sweep finishes.
- `rd_idx`, input, `IDX_W`: forward-pass read index.
- `rd_weight`, output, `fixed_point_t`: equals `weight[rd_idx]`, combinational, committed value only.
- `sat_clr`, input, 1: clears `sat_flag`.
- `sat_flag`, output, 1: sticky flag, set on any saturation event.

## Operation
- Number format: `fixed_point_t` = {`integer_fixed` s8, `decimal_fixed` 8}. Arithmetically it is treated as one 16-bit two's-complement Q8.8 word, so 1.0 = 0x0100.
- Saturating add: form the 17-bit sum of two Q8.8 words, then clamp to FP_MAX 0x7FFF or FP_MIN 0x8000. Any clamp sets `sat_flag`.
- FSM states: IDLE, APPLY, DONE.
  - IDLE: a delta transfer occurs when `delta_valid && delta_ready`. It performs `acc[delta_idx] <= sat(acc[delta_idx] + weight_delta)`.
  - IDLE to APPLY: on `commit`. The sweep counter is cleared to 0.
  - APPLY: each cycle, `weight[cnt] <= sat(weight[cnt] + acc[cnt])`, `acc[cnt] <= 0`, and `cnt` increments. When `cnt == NUM_WEIGHTS-1`, the next state is DONE.
  - DONE: `done` = 1 for one cycle, then return to IDLE.
- In APPLY and DONE, `delta_ready` = 0 and `load_valid` and `commit` are ignored.
- A delta accepted in the same cycle as `commit` is accumulated and is included in the sweep.
- In IDLE, `load_valid` and a delta transfer to the same index in the same cycle are independent. The load writes the weight; the delta goes to the accumulator.
- Any index ≥ `NUM_WEIGHTS`, for load, delta or read, is ignored. A delta with such an index is still handshaken (consumed). `rd_weight` returns 0.
- `sat_clr` and a new saturation event in the same cycle: the set wins.

## Timing
- Reset values: all weights and accumulators 0, state IDLE, `cnt` 0. Outputs: `busy` 0, `done` 0, `delta_ready` 1, `sat_flag` 0, `rd_weight` 0.
- Delta accumulate latency is 1 cycle; throughput is one delta per cycle.
- For a `commit` sampled in cycle t:
  - `busy` = 1 in cycles t+1 through t+N+1.
  - The weight at index i updates at the end of cycle t+1+i.
  - `done` = 1 in cycle t+N+1.
  - IDLE resumes in cycle t+N+2.
- `rd_weight` shows partially-swept values during APPLY. Consumers must wait for `done`.
- Reset asserted mid-sweep: the bank returns immediately to reset values and no `done` is issued.

## Structure
- Shared package `fixedpoint`:
  - `fixed_point_t`.
  - Constants `FP_MAX`, `FP_MIN`, `FP_ZERO`.
  - Function `fp_sat_add(a, b, output overflow)`.
- One combinational sub-module, `fp_sat_adder`, with two instances: the accumulate path and the apply path.
- Storage is flop arrays, with no RAM macro.

## Test plan
- Reset, then load weight[3] = 0x0100. Accept deltas 0x0080 and 0x0040 to index 3, then commit. Expect `rd_weight` at index 3 = 0x01C0, `done` exactly N+1 cycles after commit, and acc[3] = 0.
- Delta 0x0010 to index 5 presented in the same cycle as `commit`. Expect weight[5] to increase by 0x0010 in that sweep.
- Load weight[0] = 0x7F00 and apply delta 0x0200. Expect weight[0] = 0x7FFF and `sat_flag` = 1. Then `sat_clr` gives `sat_flag` = 0.
- Hold `delta_valid` during APPLY. Expect `delta_ready` = 0, no accumulation, and the delta accepted in the first IDLE cycle. A `commit` or `load_valid` during APPLY has no effect.
- Assert `rst` at sweep index 7. Expect all weights and accumulators 0, `busy` 0, and no `done` pulse.
- Two consecutive deltas 0x8000 to index 1. Expect acc[1] to clamp to 0x8000 with `sat_flag` set. After commit, weight[1] = 0x8000.
